// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared MIPS encodings, ALU op codes and control-word field offsets.
// Revision 1.0
`default_nettype none

package decode_queue_pkg;

    localparam int CTRL_W = 22;

    // Control-word bit offsets, LSB upward
    localparam int CTRL_ERET      = 0;
    localparam int CTRL_BREAK     = 1;
    localparam int CTRL_SYSCALL   = 2;
    localparam int CTRL_CP0WRITE  = 3;
    localparam int CTRL_JALR      = 4;
    localparam int CTRL_JR        = 5;
    localparam int CTRL_JAL       = 6;
    localparam int CTRL_J         = 7;
    localparam int CTRL_BAL       = 8;
    localparam int CTRL_BRANCH    = 9;
    localparam int CTRL_MEMTOREG  = 10;
    localparam int CTRL_MEMWRITE  = 11;
    localparam int CTRL_REGDST    = 12;
    localparam int CTRL_REGWRITE  = 13;
    localparam int CTRL_HILO_LO   = 14;
    localparam int CTRL_ALUSRC_LO = 16;
    localparam int CTRL_ALUOP_LO  = 18;

    // alusrc: 00 rt register, 01 sign-extended imm, 10 zero-extended imm
    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_SEXT = 2'b01;
    localparam logic [1:0] SRC_ZEXT = 2'b10;

    typedef enum logic [3:0] {
        NOP_OP    = 4'd0,
        R_TYPE_OP = 4'd1,
        ADD_OP    = 4'd2,
        ADDU_OP   = 4'd3,
        AND_OP    = 4'd4,
        OR_OP     = 4'd5,
        XOR_OP    = 4'd6,
        LUI_OP    = 4'd7,
        SLT_OP    = 4'd8,
        SLTU_OP   = 4'd9,
        SUB_OP    = 4'd10
    } aluop_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA     = 6'h03, F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR      = 6'h08, F_JALR  = 6'h09;
    localparam logic [5:0] F_SYSCALL = 6'h0C, F_BREAK = 6'h0D;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO    = 6'h12, F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV    = 6'h1A, F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB     = 6'h22, F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR     = 6'h26, F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
    localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04, RS_ERET   = 5'h10;

endpackage

`default_nettype wire

// File: rtl/decode_queue_inst_decode.sv
// inst_decode: combinational MIPS instruction word to {ctrl, ri}.
// Revision 1.0
`default_nettype none

module inst_decode
    import decode_queue_pkg::*;
(
    input  logic [31:0]       inst,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ri
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_bits;

    assign op          = inst[31:26];
    assign rs          = inst[25:21];
    assign rt          = inst[20:16];
    assign funct       = inst[5:0];
    assign unused_bits = ^inst[15:6];

    always_comb begin
        ctrl = '0;
        ri   = 1'b0;
        case (op)
            OP_SPECIAL: begin
                ctrl[CTRL_ALUOP_LO +: 4] = R_TYPE_OP;
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_SLT, F_SLTU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO: begin
                        ctrl[CTRL_REGWRITE] = 1'b1;
                        ctrl[CTRL_REGDST]   = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl[CTRL_HILO_LO +: 2] = 2'b11;
                    F_MTHI:    ctrl[CTRL_HILO_LO +: 2] = 2'b10;
                    F_MTLO:    ctrl[CTRL_HILO_LO +: 2] = 2'b01;
                    F_JR:      ctrl[CTRL_JR] = 1'b1;
                    F_JALR: begin
                        ctrl[CTRL_JALR]     = 1'b1;
                        ctrl[CTRL_REGWRITE] = 1'b1;
                        ctrl[CTRL_REGDST]   = 1'b1;
                    end
                    F_SYSCALL: ctrl[CTRL_SYSCALL] = 1'b1;
                    F_BREAK:   ctrl[CTRL_BREAK]   = 1'b1;
                    default:   ri = 1'b1;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                case (op)
                    OP_ANDI:  begin ctrl[CTRL_ALUOP_LO +: 4] = AND_OP;  ctrl[CTRL_ALUSRC_LO +: 2] = SRC_ZEXT; end
                    OP_ORI:   begin ctrl[CTRL_ALUOP_LO +: 4] = OR_OP;   ctrl[CTRL_ALUSRC_LO +: 2] = SRC_ZEXT; end
                    OP_XORI:  begin ctrl[CTRL_ALUOP_LO +: 4] = XOR_OP;  ctrl[CTRL_ALUSRC_LO +: 2] = SRC_ZEXT; end
                    OP_LUI:   begin ctrl[CTRL_ALUOP_LO +: 4] = LUI_OP;  ctrl[CTRL_ALUSRC_LO +: 2] = SRC_ZEXT; end
                    OP_ADDI:  begin ctrl[CTRL_ALUOP_LO +: 4] = ADD_OP;  ctrl[CTRL_ALUSRC_LO +: 2] = SRC_SEXT; end
                    OP_ADDIU: begin ctrl[CTRL_ALUOP_LO +: 4] = ADDU_OP; ctrl[CTRL_ALUSRC_LO +: 2] = SRC_SEXT; end
                    OP_SLTI:  begin ctrl[CTRL_ALUOP_LO +: 4] = SLT_OP;  ctrl[CTRL_ALUSRC_LO +: 2] = SRC_SEXT; end
                    default:  begin ctrl[CTRL_ALUOP_LO +: 4] = SLTU_OP; ctrl[CTRL_ALUSRC_LO +: 2] = SRC_SEXT; end
                endcase
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                ctrl[CTRL_ALUOP_LO +: 4] = SUB_OP;
                ctrl[CTRL_BRANCH]        = 1'b1;
            end
            OP_REGIMM: begin
                ctrl[CTRL_ALUOP_LO +: 4] = SUB_OP;
                ctrl[CTRL_BRANCH]        = 1'b1;
                case (rt)
                    RT_BLTZ, RT_BGEZ: ;
                    RT_BLTZAL, RT_BGEZAL: begin
                        ctrl[CTRL_BAL]      = 1'b1;
                        ctrl[CTRL_REGWRITE] = 1'b1;
                    end
                    default: ri = 1'b1;
                endcase
            end
            OP_J:   ctrl[CTRL_J] = 1'b1;
            OP_JAL: begin
                ctrl[CTRL_JAL]      = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                ctrl[CTRL_ALUOP_LO +: 4]  = ADDU_OP;
                ctrl[CTRL_ALUSRC_LO +: 2] = SRC_SEXT;
                ctrl[CTRL_REGWRITE]       = 1'b1;
                ctrl[CTRL_MEMTOREG]       = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl[CTRL_ALUOP_LO +: 4]  = ADDU_OP;
                ctrl[CTRL_ALUSRC_LO +: 2] = SRC_SEXT;
                ctrl[CTRL_MEMWRITE]       = 1'b1;
            end
            OP_COP0: begin
                case (rs)
                    RS_MFC0: ctrl[CTRL_REGWRITE] = 1'b1;
                    RS_MTC0: ctrl[CTRL_CP0WRITE] = 1'b1;
                    RS_ERET: ctrl[CTRL_ERET]     = 1'b1;
                    default: ri = 1'b1;
                endcase
            end
            default: ri = 1'b1;
        endcase
        // Reserved instructions carry no control so nothing downstream acts on a partial decode
        if (ri) begin
            ctrl = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched instructions and buffers them in a DEPTH-entry circular queue.
// Revision 1.0
`default_nettype none

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    input  logic                       in_is_ds,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic                       out_ri,
    output logic                       out_is_ds,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];
    logic [CTRL_W-1:0] ctrl_mem [DEPTH];
    logic              ri_mem   [DEPTH];
    logic              ds_mem   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic              fence;
    logic              push;
    logic              pop;
    logic              trap;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_ri;

    inst_decode u_inst_decode (
        .inst (in_inst),
        .ctrl (dec_ctrl),
        .ri   (dec_ri)
    );

    assign trap      = dec_ri | dec_ctrl[CTRL_SYSCALL] | dec_ctrl[CTRL_BREAK] | dec_ctrl[CTRL_ERET];
    assign in_ready  = (count != FULL_CNT) && !fence;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fence  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fence  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            // Fetch stays blocked until everything up to and including the trap has left
            if (push && trap) begin
                fence <= 1'b1;
            end else if (count_next == '0) begin
                fence <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
            ctrl_mem[wr_ptr] <= dec_ctrl;
            ri_mem[wr_ptr]   <= dec_ri;
            ds_mem[wr_ptr]   <= in_is_ds;
        end
    end

    // Storage is never reset, so head fields are masked to zero while empty
    assign out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;
    assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;
    assign out_ctrl  = out_valid ? ctrl_mem[rd_ptr] : '0;
    assign out_ri    = out_valid ? ri_mem[rd_ptr]   : 1'b0;
    assign out_is_ds = out_valid ? ds_mem[rd_ptr]   : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed self-checking bench for decode_queue (DEPTH = 4).
// Revision 1.0
`default_nettype none

module tb_decode_queue;

    localparam logic [31:0] ADDU_INST = 32'h0085_1021;
    localparam logic [21:0] ADDU_CTRL = 22'h04_3000;
    localparam logic [31:0] LW_INST   = 32'h8C82_0004;
    localparam logic [21:0] LW_CTRL   = 22'h0D_2400;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_is_ds;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [21:0] out_ctrl;
    logic        out_ri;
    logic        out_is_ds;
    logic        flush;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_is_ds  (in_is_ds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ctrl  (out_ctrl),
        .out_ri    (out_ri),
        .out_is_ds (out_is_ds),
        .flush     (flush),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic decode_case(input logic [31:0] inst, input logic [21:0] exp_ctrl,
                               input logic [31:0] pc, input logic ds);
        in_valid  = 1'b1;
        in_inst   = inst;
        in_pc     = pc;
        in_is_ds  = ds;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check($sformatf("ctrl_%08h", inst), out_ctrl, exp_ctrl);
        check($sformatf("ri_%08h", inst), out_ri, 1'b0);
        check($sformatf("inst_%08h", inst), out_inst, inst);
        check($sformatf("pc_%08h", inst), out_pc, pc);
        check($sformatf("ds_%08h", inst), out_is_ds, ds);
        check($sformatf("ready_%08h", inst), in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_is_ds  = 1'b0;
        check($sformatf("drain_%08h", inst), count, 3'd0);
    endtask

    // A trap entry must hold off a following ADDU until it has popped
    task automatic fence_case(input logic [31:0] inst, input logic [21:0] exp_ctrl,
                              input logic exp_ri, input logic [31:0] pc);
        in_valid  = 1'b1;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = 1'b0;
        step();
        in_inst = ADDU_INST;
        in_pc   = pc + 32'd4;
        check($sformatf("tctrl_%08h", inst), out_ctrl, exp_ctrl);
        check($sformatf("tri_%08h", inst), out_ri, exp_ri);
        check($sformatf("tfence_%08h", inst), in_ready, 1'b0);
        step();
        step();
        check($sformatf("theld_%08h", inst), count, 3'd1);
        check($sformatf("thead_%08h", inst), out_pc, pc);
        out_ready = 1'b1;
        step();
        check($sformatf("tempty_%08h", inst), count, 3'd0);
        check($sformatf("treopen_%08h", inst), in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check($sformatf("tnext_cnt_%08h", inst), count, 3'd1);
        check($sformatf("tnext_pc_%08h", inst), out_pc, pc + 32'd4);
        check($sformatf("tnext_ctrl_%08h", inst), out_ctrl, ADDU_CTRL);
        step();
        out_ready = 1'b0;
        check($sformatf("tdone_%08h", inst), count, 3'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        in_is_ds  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_ctrl", out_ctrl, 22'd0);
        resetn = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1'b1);

        // ADDU through the queue
        in_valid  = 1'b1;
        in_inst   = ADDU_INST;
        in_pc     = 32'hBFC0_0000;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("addu_valid", out_valid, 1'b1);
        check("addu_pc", out_pc, 32'hBFC0_0000);
        check("addu_ctrl", out_ctrl, ADDU_CTRL);
        check("addu_ri", out_ri, 1'b0);
        check("addu_count", count, 3'd1);
        step();
        check("addu_popped", count, 3'd0);
        check("addu_empty_valid", out_valid, 1'b0);
        out_ready = 1'b0;

        // Fill to full, then stream across the pointer wrap
        in_valid = 1'b1;
        in_inst  = LW_INST;
        in_pc    = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            step();
            in_pc = in_pc + 32'd4;
        end
        check("full_count", count, 3'd4);
        check("full_ready", in_ready, 1'b0);
        check("full_ctrl", out_ctrl, LW_CTRL);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("wrap_pc_%0d", k), out_pc, 32'h0000_1000 + 32'(4 * k));
            check($sformatf("wrap_ready_%0d", k), in_ready, (k != 0));
            step();
            if (k != 0) begin
                in_pc = in_pc + 32'd4;
            end
            // The pop out of full frees one slot a cycle before a push can fill it
            check($sformatf("wrap_count_%0d", k), count, 3'd3);
        end
        in_valid = 1'b0;
        step();
        step();
        step();
        check("wrap_drained", count, 3'd0);
        out_ready = 1'b0;

        decode_case(32'h3421_0001, 22'h16_2000, 32'h0000_5000, 1'b0);
        decode_case(32'hAC82_0008, 22'h0D_0800, 32'h0000_5004, 1'b1);
        decode_case(32'h0411_0003, 22'h28_2300, 32'h0000_5008, 1'b0);
        decode_case(32'h0040_F809, 22'h04_3010, 32'h0000_500C, 1'b0);
        decode_case(32'h0085_0018, 22'h04_C000, 32'h0000_5010, 1'b0);
        decode_case(32'h4082_6000, 22'h00_0008, 32'h0000_5014, 1'b0);
        decode_case(32'h1085_0003, 22'h28_0200, 32'h0000_5018, 1'b0);

        fence_case(32'hFC00_0000, 22'h00_0000, 1'b1, 32'h0000_2000);
        fence_case(32'h0000_000C, 22'h04_0004, 1'b0, 32'h0000_2100);
        fence_case(32'h0000_000D, 22'h04_0002, 1'b0, 32'h0000_2200);
        fence_case(32'h4200_0018, 22'h00_0001, 1'b0, 32'h0000_2300);
        fence_case(32'h0000_0001, 22'h00_0000, 1'b1, 32'h0000_2400);
        fence_case(32'h0405_0000, 22'h00_0000, 1'b1, 32'h0000_2500);

        // Flush beats a same-cycle push and pop
        in_valid = 1'b1;
        in_inst  = ADDU_INST;
        in_pc    = 32'h0000_4000;
        for (int i = 0; i < 3; i++) begin
            step();
            in_pc = in_pc + 32'd4;
        end
        check("flush_pre_count", count, 3'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", count, 3'd0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        step();
        check("flush_dropped", count, 3'd0);
        out_ready = 1'b0;

        in_valid = 1'b1;
        in_inst  = 32'h0000_000C;
        step();
        in_valid = 1'b0;
        check("flush_fence_set", in_ready, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_fence_clr", in_ready, 1'b1);
        check("flush_fence_cnt", count, 3'd0);

        // Asynchronous reset between edges
        in_valid = 1'b1;
        in_inst  = ADDU_INST;
        in_pc    = 32'h0000_3000;
        step();
        in_pc = 32'h0000_3004;
        step();
        in_valid = 1'b0;
        check("arst_pre_count", count, 3'd2);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_count", count, 3'd0);
        check("arst_pc", out_pc, 32'd0);
        #1;
        resetn = 1'b1;
        check("arst_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_inst  = LW_INST;
        in_pc    = 32'h0000_3100;
        step();
        in_valid = 1'b0;
        check("arst_push_count", count, 3'd1);
        check("arst_push_pc", out_pc, 32'h0000_3100);
        check("arst_push_ctrl", out_ctrl, LW_CTRL);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("arst_pop", count, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
